// File: rtl/lexicon_apb_initiator_pkg.sv
// Shared types for the APB initiator: FSM state, response record and index-width helper.
package lexicon_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_DATA_W     = 32;
  localparam int APB_ADDR_W     = 8;
  localparam int APB_PADDR_SIZE = 4;

  // Upper request-address bits that remain after the APB address is stripped off.
  function automatic int idx_width(input int addr_w, input int paddr_size);
    return addr_w - paddr_size;
  endfunction

  localparam int APB_IDX_W = idx_width(APB_ADDR_W, APB_PADDR_SIZE);

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/lexicon_apb_initiator_if.sv
// Request/response channels plus the APB segment of the initiator, with master (initiator) and slave (environment) views.
interface lexicon_apb_initiator_if #(
  parameter int NUM_SLV    = 4,
  parameter int ADDR_W     = 8,
  parameter int PADDR_SIZE = 4,
  parameter int DATA_W     = 32
);
  // Handshakes: a transfer happens on a rising clock edge where valid & ready are both 1;
  // the producer holds valid and payload steady until that edge, ready may change freely.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [PADDR_SIZE-1:0] paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );

endinterface

// File: rtl/lexicon_apb_initiator_timeout.sv
// ACCESS wait-cycle counter; o_expired flags the wait cycle whose increment reaches TIMEOUT.
module lexicon_apb_timeout #(
  parameter  int TIMEOUT = 255,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic pclk,
  input  logic prst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag one cycle early so the bus drops right after the counter hits TIMEOUT.
  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lexicon_apb_initiator.sv
// APB requester: one request at a time through SETUP/ACCESS, result returned on the response channel.
// Optional ACCESS timeout is built when APB_TIMEOUT_EN is defined.
module lexicon_apb_initiator
  import lexicon_apb_pkg::*;
#(
  parameter int NUM_SLV    = 4,
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int PADDR_SIZE = APB_PADDR_SIZE,
  parameter int DATA_W     = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 255
`endif
) (
  input  logic                    pclk,
  input  logic                    prst,
  lexicon_apb_initiator_if.master bus,
  output apb_state_e              o_dbg_state
);

  localparam int IDX_W  = idx_width(ADDR_W, PADDR_SIZE);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [IDX_W:0] NUM_SLV_L = (IDX_W + 1)'(NUM_SLV);

  apb_state_e            r_state;
  apb_state_e            w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [PADDR_SIZE-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_W-1:0]     r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  apb_rsp_t              r_rsp;

  logic [IDX_W-1:0]      w_req_idx;
  logic                  w_dec_ok;
  logic                  w_req_ready;
  logic                  w_hs;
  logic                  w_tmo_hit;

  assign w_req_idx   = bus.req_addr[ADDR_W-1:PADDR_SIZE];
  assign w_dec_ok    = ({1'b0, w_req_idx} < NUM_SLV_L);
  // Held low during reset so nothing can be accepted until prst releases.
  assign w_req_ready = (r_state == IDLE) && !prst;
  assign w_hs        = bus.req_valid && w_req_ready;

`ifdef APB_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_tmo_inc;
  logic w_tmo_expired;

  assign w_tmo_clr = (r_state == SETUP);
  assign w_tmo_inc = (r_state == ACCESS) && !bus.pready;
  assign w_tmo_hit = w_tmo_inc && w_tmo_expired;

  lexicon_apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .pclk      (pclk),
    .prst      (prst),
    .i_clr     (w_tmo_clr),
    .i_inc     (w_tmo_inc),
    .o_expired (w_tmo_expired)
  );
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_hs) w_next = w_dec_ok ? SETUP : RESP;
      SETUP:  w_next = ACCESS;
      ACCESS: if (bus.pready || w_tmo_hit) w_next = RESP;
      RESP:   if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // APB payload is captured once per accepted, decodable request and held afterwards.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_idx    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_hs && w_dec_ok) begin
      r_idx    <= w_req_idx;
      r_paddr  <= bus.req_addr[PADDR_SIZE-1:0];
      r_pwrite <= bus.req_write;
      r_pwdata <= bus.req_wdata;
      r_pstrb  <= bus.req_write ? bus.req_strb : '0;
    end
  end

  // Read data is returned only for successful reads; every error path reports zero data.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_rsp <= '0;
    end else if (w_hs && !w_dec_ok) begin
      r_rsp.rdata <= '0;
      r_rsp.err   <= 1'b1;
    end else if (r_state == ACCESS && bus.pready) begin
      r_rsp.rdata <= (!r_pwrite && !bus.pslverr) ? APB_DATA_W'(bus.prdata) : '0;
      r_rsp.err   <= bus.pslverr;
    end else if (r_state == ACCESS && w_tmo_hit) begin
      r_rsp.rdata <= '0;
      r_rsp.err   <= 1'b1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = DATA_W'(r_rsp.rdata);
  assign bus.rsp_err   = r_rsp.err;
  assign bus.psel      = (r_state == SETUP || r_state == ACCESS) ? (NUM_SLV'(1) << r_idx) : '0;
  assign bus.penable   = (r_state == ACCESS);
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.pstrb     = r_pstrb;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lexicon_apb_initiator.sv
// Directed bench for lexicon_apb_initiator: cycle-exact checks of request, APB and response channels.
module tb_lexicon_apb_initiator;
  import lexicon_apb_pkg::*;

  localparam int NUM_SLV    = 4;
  localparam int ADDR_W     = 8;
  localparam int PADDR_SIZE = 4;
  localparam int DATA_W     = 32;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  apb_state_e dbg_state;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         pen_cnt;

  lexicon_apb_initiator_if #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .PADDR_SIZE(PADDR_SIZE), .DATA_W(DATA_W)
  ) bus ();

  lexicon_apb_initiator #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .PADDR_SIZE(PADDR_SIZE), .DATA_W(DATA_W)
`ifdef APB_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .pclk        (pclk),
    .prst        (prst),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_psel",      bus.psel, 0);
    check("rst_penable",   bus.penable, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_paddr",     bus.paddr, 0);
    check("rst_state",     dbg_state, IDLE);
    prst = 1'b0;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1);

    // Write 0x12, zero wait states
    tick();
    drive_req(1'b1, 8'h12, 32'hA5A5_0001, 4'hF);
    bus.pready = 1'b1;
    check("t1_c0_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("t1_c1_state",   dbg_state, SETUP);
    check("t1_c1_psel",    bus.psel, 4'b0010);
    check("t1_c1_penable", bus.penable, 0);
    check("t1_c1_paddr",   bus.paddr, 4'h2);
    check("t1_c1_pwrite",  bus.pwrite, 1);
    check("t1_c1_pwdata",  bus.pwdata, 32'hA5A5_0001);
    check("t1_c1_pstrb",   bus.pstrb, 4'hF);
    check("t1_c1_req_ready", bus.req_ready, 0);
    tick();
    check("t1_c2_psel",    bus.psel, 4'b0010);
    check("t1_c2_penable", bus.penable, 1);
    check("t1_c2_rsp_valid", bus.rsp_valid, 0);
    tick();
    check("t1_c3_rsp_valid", bus.rsp_valid, 1);
    check("t1_c3_rsp_err",   bus.rsp_err, 0);
    check("t1_c3_rsp_rdata", bus.rsp_rdata, 0);
    check("t1_c3_psel",      bus.psel, 0);
    check("t1_c3_penable",   bus.penable, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t1_c4_req_ready", bus.req_ready, 1);
    check("t1_c4_rsp_valid", bus.rsp_valid, 0);

    // Read 0x03, three wait states, pslverr asserted only while pready is low
    drive_req(1'b0, 8'h03, 32'hFFFF_FFFF, 4'hF);
    bus.pready  = 1'b0;
    bus.pslverr = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("t2_c1_psel",   bus.psel, 4'b0001);
    check("t2_c1_paddr",  bus.paddr, 4'h3);
    check("t2_c1_pwrite", bus.pwrite, 0);
    check("t2_c1_pstrb",  bus.pstrb, 0);
    pen_cnt = 0;
    for (int cyc = 2; cyc <= 5; cyc++) begin
      tick();
      if (cyc == 5) begin
        bus.pready  = 1'b1;
        bus.prdata  = 32'hDEAD_BEEF;
        bus.pslverr = 1'b0;
      end
      if (bus.penable) pen_cnt++;
    end
    check("t2_c5_paddr_stable", bus.paddr, 4'h3);
    tick();
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    if (bus.penable) pen_cnt++;
    check("t2_penable_cycles", pen_cnt, 4);
    check("t2_c6_rsp_valid",   bus.rsp_valid, 1);
    check("t2_c6_rsp_rdata",   bus.rsp_rdata, 32'hDEAD_BEEF);
    check("t2_c6_rsp_err",     bus.rsp_err, 0);

    // Response back-pressure: five cycles without rsp_ready
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_rsp_valid", bus.rsp_valid, 1);
      check("t5_hold_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      check("t5_hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t5_release_state", dbg_state, IDLE);

    // Read with slave error; second request held during the transfer
    drive_req(1'b0, 8'h23, 32'h0, 4'hF);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h1234_5678;
    tick();
    drive_req(1'b1, 8'h11, 32'h0BAD_F00D, 4'h3);
    check("t3_c1_psel",      bus.psel, 4'b0100);
    check("t3_c1_req_ready", bus.req_ready, 0);
    tick();
    check("t3_c2_req_ready", bus.req_ready, 0);
    check("t3_c2_state",     dbg_state, ACCESS);
    tick();
    check("t3_c3_rsp_valid", bus.rsp_valid, 1);
    check("t3_c3_rsp_err",   bus.rsp_err, 1);
    check("t3_c3_rsp_rdata", bus.rsp_rdata, 0);
    check("t3_c3_req_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    bus.pslverr   = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;
    check("t3_c4_state",     dbg_state, IDLE);
    check("t3_c4_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("t3_c5_state",  dbg_state, SETUP);
    check("t3_c5_psel",   bus.psel, 4'b0010);
    check("t3_c5_paddr",  bus.paddr, 4'h1);
    check("t3_c5_pwrite", bus.pwrite, 1);
    check("t3_c5_pwdata", bus.pwdata, 32'h0BAD_F00D);
    check("t3_c5_pstrb",  bus.pstrb, 4'h3);
    tick();
    tick();
    check("t3_c7_rsp_valid", bus.rsp_valid, 1);
    check("t3_c7_rsp_err",   bus.rsp_err, 0);
    check("t3_c7_rsp_rdata", bus.rsp_rdata, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Decode error: index 5 with four slaves
    drive_req(1'b0, 8'h57, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    check("t4_c1_rsp_valid", bus.rsp_valid, 1);
    check("t4_c1_rsp_err",   bus.rsp_err, 1);
    check("t4_c1_rsp_rdata", bus.rsp_rdata, 0);
    check("t4_c1_psel",      bus.psel, 0);
    check("t4_c1_penable",   bus.penable, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t4_c2_req_ready", bus.req_ready, 1);

    // Reset pulsed mid-ACCESS
    drive_req(1'b0, 8'h01, 32'h0, 4'h0);
    bus.pready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t6_c2_psel",    bus.psel, 4'b0001);
    check("t6_c2_penable", bus.penable, 1);
    #2;
    prst = 1'b1;
    #1;
    check("t6_async_psel",      bus.psel, 0);
    check("t6_async_penable",   bus.penable, 0);
    check("t6_async_req_ready", bus.req_ready, 0);
    check("t6_async_paddr",     bus.paddr, 0);
    check("t6_async_state",     dbg_state, IDLE);
    tick();
    prst       = 1'b0;
    bus.pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_rsp", bus.rsp_valid, 0);
    end
    check("t6_req_ready", bus.req_ready, 1);
    bus.pready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // ACCESS timeout with pready stuck low, TIMEOUT = 4
    drive_req(1'b0, 8'h00, 32'h0, 4'h0);
    bus.prdata = 32'h5555_AAAA;
    tick();
    bus.req_valid = 1'b0;
    pen_cnt = 0;
    for (int cyc = 2; cyc <= 5; cyc++) begin
      tick();
      if (bus.penable) pen_cnt++;
    end
    tick();
    if (bus.penable) pen_cnt++;
    check("t7_penable_cycles", pen_cnt, 4);
    check("t7_psel",           bus.psel, 0);
    check("t7_rsp_valid",      bus.rsp_valid, 1);
    check("t7_rsp_err",        bus.rsp_err, 1);
    check("t7_rsp_rdata",      bus.rsp_rdata, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t7_idle", dbg_state, IDLE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lexicon_apb_initiator.md
# lexicon_apb_initiator

APB requester that converts a simple valid/ready request channel into APB SETUP/ACCESS transfers and returns the read data and error status on a valid/ready response channel. It sits between a core-side load/store port or bus bridge and the peripheral APB segment (GPIO, UART, timers). It drives one-hot `psel` to up to `NUM_SLV` responders and handles wait states signalled by `pready`.

## Interface
- `NUM_SLV`, 4: number of APB responders; width of `psel`.
- `ADDR_W`, 8: request address width.
- `PADDR_SIZE`, 4: APB address width; the low bits of the request address.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT`, 255: maximum ACCESS cycles before abort; used only with `APB_TIMEOUT_EN`.
- `pclk` in 1: clock.
- `prst` in 1: asynchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: bits `[ADDR_W-1:PADDR_SIZE]` select the slave index; bits `[PADDR_SIZE-1:0]` become `paddr`.
- `req_wdata` in `DATA_W`: write data.
- `req_strb` in `DATA_W/8`: byte strobes.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and errors.
- `rsp_err` out 1: `pslverr`, decode error, or timeout.
- `psel` out `NUM_SLV`: one-hot slave select.
- `penable` out 1: ACCESS phase.
- `pwrite` out 1: APB write.
- `paddr` out `PADDR_SIZE`: APB address.
- `pwdata` out `DATA_W`: APB write data.
- `pstrb` out `DATA_W/8`: APB strobes.
- `prdata` in `DATA_W`: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On handshake, latch write, address, data and strobes.
    - Slave index < `NUM_SLV` → go to SETUP.
    - Otherwise → go to RESP with `rsp_err=1` and `rsp_rdata=0`; no APB activity occurs.
  - SETUP: `psel[idx]=1`, `penable=0`. Always go to ACCESS the next cycle.
  - ACCESS: `psel[idx]=1`, `penable=1`. Hold until `pready=1`.
    - On `pready`, capture `prdata` (reads only; writes capture 0) and `pslverr` into the response registers, then go to RESP.
  - RESP: `rsp_valid=1`, with `psel` and `penable` both 0. On `rsp_ready=1`, go to IDLE.
- `req_ready=0` in every state except IDLE, so at most one transfer is outstanding.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are registered.
  - They are stable from SETUP through the last ACCESS cycle.
  - They hold their values afterwards.
- `pstrb` is forced to 0 on reads.
- `rsp_rdata` and `rsp_err` are stable while `rsp_valid=1`.
- Boundary conditions:
  - `pready=1` in the first ACCESS cycle: zero wait states.
  - `pslverr` is ignored unless `pready=1`.
  - `req_valid` is ignored outside IDLE.
- Reset, including mid-transfer: state returns to IDLE immediately.
  - All outputs become 0, except `req_ready`, which becomes 1 once `prst` deasserts.
  - No response is produced for an aborted transfer.

## Timing
- Request handshake at cycle 0. SETUP at cycle 1. ACCESS from cycle 2. `rsp_valid` from cycle 2+W+1, where W is the number of wait cycles with `pready=0`.
- With no wait states, `rsp_valid` is first high at cycle 3.
- Decode error: `rsp_valid` at cycle 1.
- Minimum back-to-back period is 4 cycles: response consumed in cycle 3, IDLE in cycle 4.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - An 8-bit counter (sized by `$clog2(TIMEOUT+1)`) clears on entry to ACCESS and increments each ACCESS cycle with `pready=0`.
  - When the counter reaches `TIMEOUT`, the transfer aborts: `psel` and `penable` drop the next cycle, and RESP follows with `rsp_err=1` and `rsp_rdata=0`.
  - `pready` in the same cycle as the timeout hit takes priority and completes normally.
- `APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package `lexicon_apb_pkg`:
  - State enum `apb_state_e` (IDLE, SETUP, ACCESS, RESP).
  - Response struct `apb_rsp_t` (rdata, err).
  - Localparam helpers for slave-index width.
- One sub-module, `lexicon_apb_timeout`: counter with clear and increment inputs and an `expired` output. Instantiated only under `APB_TIMEOUT_EN`.

## Test plan
- Write, addr 0x12, data 0xA5A5_0001, strb 0xF, `pready=1` immediately → `psel=4'b0010`, `paddr=2`, SETUP at cycle 1, ACCESS at cycle 2, `rsp_valid` at cycle 3, `rsp_err=0`, `rsp_rdata=0`.
- Read, addr 0x03, slave holds `pready=0` for 3 cycles then returns `prdata=0xDEAD_BEEF` → `penable` high for 4 cycles, `pstrb=0`, `rsp_rdata=0xDEAD_BEEF` at cycle 6.
- Read with `pready=1`, `pslverr=1` → `rsp_err=1`; a second request asserted during the transfer is not accepted until IDLE.
- With `NUM_SLV=4`, addr 0x57 (index 5) → no `psel`, `rsp_valid` at cycle 1 with `rsp_err=1`.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_rdata` stable, `req_ready=0`. Then `prst` pulsed mid-ACCESS on a new transfer → `psel` and `penable` 0 asynchronously, and no response follows.
- `APB_TIMEOUT_EN`, `TIMEOUT=4`, `pready` stuck low → ACCESS lasts 4 cycles, then `rsp_err=1`, `rsp_rdata=0`.
